// File: rtl/digit_scan_driver.sv
// Four-digit scan driver for a multiplexed seven-segment display.
// Rotates a one-hot nibble select at a prescaled rate and drives the
// matching active-low anodes, with per-digit masking and optional
// leading-zero blanking. Anodes deliberately trail sel by one cycle so
// every digit change passes through a settling cycle (ghost suppression).
module digit_scan_driver #(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] N,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  sel,
  output logic [3:0]  an,
  output logic [1:0]  idx,
  output logic        tick,
  output logic        frame
);

  // A prescale of 0 would never advance; it behaves as 1 instead.
  localparam int             PS_EFF = (PRESCALE < 1) ? 1 : PRESCALE;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PS_EFF - 1);

  logic [CNT_W-1:0] cnt;
  logic             adv;
  logic [3:0]       vis;

  // Digit d is blanked when it and every digit to its left are zero;
  // the units digit always stays visible when enabled.
  function automatic logic [3:0] visibility(input logic [15:0] n,
                                            input logic [3:0]  de,
                                            input logic        lz);
    logic [3:0] v;
    v[3] = de[3] & ~(lz & (n[15:12] == 4'h0));
    v[2] = de[2] & ~(lz & (n[15:8]  == 8'h00));
    v[1] = de[1] & ~(lz & (n[15:4]  == 12'h000));
    v[0] = de[0];
    return v;
  endfunction

  // Slot-end detection and current visibility mask.
  always_comb begin
    adv = en && (cnt == LAST);
    vis = visibility(N, digit_en, lz_blank);
  end

  // Prescaler, digit rotation, strobes and anode register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      sel   <= 4'b1000;
      idx   <= 2'd3;
      an    <= 4'b1111;
      tick  <= 1'b0;
      frame <= 1'b0;
    end else begin
      tick  <= adv;
      frame <= adv && (sel == 4'b0001);
      if (en) begin
        cnt <= adv ? '0 : cnt + 1'b1;
      end
      if (adv) begin
        sel <= {sel[0], sel[3:1]};
        idx <= idx - 2'd1;
      end
      // Uses the pre-edge sel, giving the intended one-cycle anode lag.
      an <= en ? ~(sel & vis) : 4'b1111;
    end
  end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver: a PRESCALE=4 instance for the
// main sequences and a PRESCALE=1 instance for the every-cycle case.
module tb_digit_scan_driver;

  logic        clk;
  logic        rst_n, rst1_n;
  logic        en, en1;
  logic [15:0] N;
  logic [3:0]  digit_en;
  logic        lz_blank;

  logic [3:0]  sel, an, sel1, an1;
  logic [1:0]  idx, idx1;
  logic        tick, frame, tick1, frame1;

  int checks = 0;
  int errors = 0;

  digit_scan_driver #(.PRESCALE(4), .CNT_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .N(N), .digit_en(digit_en),
    .lz_blank(lz_blank), .sel(sel), .an(an), .idx(idx), .tick(tick),
    .frame(frame)
  );

  digit_scan_driver #(.PRESCALE(1), .CNT_W(17)) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .N(N), .digit_en(digit_en),
    .lz_blank(lz_blank), .sel(sel1), .an(an1), .idx(idx1), .tick(tick1),
    .frame(frame1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Brief reset pulse placed between edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // Runs one full frame (16 edges) from a fresh reset with en=1 and checks
  // an against the per-slot table a[s], plus sel/idx/tick/frame timing.
  task automatic run_frame(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                           input logic [3:0] a2, input logic [3:0] a3);
    logic [3:0] tbl [4];
    logic [3:0] es;
    int s;
    tbl[0] = a0; tbl[1] = a1; tbl[2] = a2; tbl[3] = a3;
    for (int k = 1; k <= 16; k++) begin
      step();
      s  = (k - 1) / 4;
      es = 4'b1000 >> ((k / 4) % 4);
      chk({tag, "_an"},     {12'h0, an},       {12'h0, tbl[s]});
      chk({tag, "_sel"},    {12'h0, sel},      {12'h0, es});
      chk({tag, "_idx"},    {14'h0, idx},      16'(3 - ((k / 4) % 4)));
      chk({tag, "_tick"},   {15'h0, tick},     {15'h0, (k % 4) == 0});
      chk({tag, "_frame"},  {15'h0, frame},    {15'h0, k == 16});
      chk({tag, "_onehot"}, 16'($countones(sel)), 16'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    en = 1'b1; en1 = 1'b1;
    N = 16'h1234; digit_en = 4'b1111; lz_blank = 1'b0;
    #12;
    chk("rst_sel",   {12'h0, sel},   16'h0008);
    chk("rst_idx",   {14'h0, idx},   16'd3);
    chk("rst_an",    {12'h0, an},    16'h000F);
    chk("rst_tick",  {15'h0, tick},  16'd0);
    chk("rst_frame", {15'h0, frame}, 16'd0);
    chk("rst1_tick", {15'h0, tick1}, 16'd0);
    chk("rst1_sel",  {12'h0, sel1},  16'h0008);

    // Plain scan of 1234, all digits visible.
    rst_n = 1'b1;
    run_frame("scan", 4'b0111, 4'b1011, 4'b1101, 4'b1110);

    // Leading-zero blanking of 0042 and 0000.
    N = 16'h0042; lz_blank = 1'b1;
    pulse_reset();
    run_frame("lz42", 4'b1111, 4'b1111, 4'b1101, 4'b1110);
    N = 16'h0000;
    pulse_reset();
    run_frame("lz00", 4'b1111, 4'b1111, 4'b1111, 4'b1110);

    // Digit mask 1010 with FFFF.
    N = 16'hFFFF; lz_blank = 1'b0; digit_en = 4'b1010;
    pulse_reset();
    run_frame("mask", 4'b0111, 4'b1111, 4'b1101, 4'b1111);

    // Enable freeze at cnt=2, sel=0100.
    N = 16'h1234; digit_en = 4'b1111;
    pulse_reset();
    for (int k = 1; k <= 6; k++) step();
    chk("frz_pre_sel", {12'h0, sel}, 16'h0004);
    chk("frz_pre_an",  {12'h0, an},  16'h000B);
    en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("frz_an",   {12'h0, an},    16'h000F);
      chk("frz_sel",  {12'h0, sel},   16'h0004);
      chk("frz_idx",  {14'h0, idx},   16'd2);
      chk("frz_tick", {15'h0, tick},  16'd0);
    end
    en = 1'b1;
    step();
    chk("res1_sel",  {12'h0, sel},  16'h0004);
    chk("res1_tick", {15'h0, tick}, 16'd0);
    chk("res1_an",   {12'h0, an},   16'h000B);
    step();
    chk("res2_sel",  {12'h0, sel},  16'h0002);
    chk("res2_idx",  {14'h0, idx},  16'd1);
    chk("res2_tick", {15'h0, tick}, 16'd1);

    // Asynchronous reset between edges while sel=0010 and tick high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel",   {12'h0, sel},   16'h0008);
    chk("arst_idx",   {14'h0, idx},   16'd3);
    chk("arst_an",    {12'h0, an},    16'h000F);
    chk("arst_tick",  {15'h0, tick},  16'd0);
    chk("arst_frame", {15'h0, frame}, 16'd0);
    rst_n = 1'b1;

    // PRESCALE=1 instance: rotate every enabled edge.
    step();
    rst1_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("p1_sel",    {12'h0, sel1},   16'(4'b1000 >> (k % 4)));
      chk("p1_tick",   {15'h0, tick1},  16'd1);
      chk("p1_frame",  {15'h0, frame1}, {15'h0, (k % 4) == 0});
      chk("p1_onehot", 16'($countones(sel1)), 16'd1);
    end
    en1 = 1'b0;
    step();
    chk("p1_off_tick", {15'h0, tick1}, 16'd0);
    chk("p1_off_an",   {12'h0, an1},   16'h000F);
    chk("p1_off_sel",  {12'h0, sel1},  16'h0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
